// File: rtl/rf_seq_pkg.sv
// Shared types and constants for the register-file port sequencer.
// The optional same-register read skip is enabled with RF_SEQ_SAME_REG_SKIP_EN.
package rf_seq_pkg;

    localparam int XLEN      = 32;
    localparam int AW        = 5;
    localparam int RF_ADDR_W = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } grant_t;

endpackage

// File: rtl/rf_seq_arb.sv
// Two-requester round-robin arbiter; only arbitrates (and remembers the winner)
// while en is high, so grants outside the idle state never disturb the history.
module rf_seq_arb (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rd_req,
    input  logic wr_req,
    output logic gnt_rd,
    output logic gnt_wr
);
    import rf_seq_pkg::*;

    grant_t last_grant;

    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (en) begin
            if (rd_req && wr_req) begin
                if (last_grant == READ) gnt_wr = 1'b1;
                else                    gnt_rd = 1'b1;
            end else begin
                gnt_rd = rd_req;
                gnt_wr = wr_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)        last_grant <= READ;
        else if (gnt_wr) last_grant <= WRITE;
        else if (gnt_rd) last_grant <= READ;
    end

endmodule

// File: rtl/regfile_port_sequencer.sv
// Shares one single-port register file between operand fetch (rs1+rs2) and writeback.
// Optional RF_SEQ_SAME_REG_SKIP_EN: when rs1==rs2, one read fills both operands.
module regfile_port_sequencer #(
    parameter int XLEN      = rf_seq_pkg::XLEN,
    parameter int AW        = rf_seq_pkg::AW,
    parameter int RF_ADDR_W = rf_seq_pkg::RF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [XLEN-1:0]      op_rs1_data,
    output logic [XLEN-1:0]      op_rs2_data,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    output logic [RF_ADDR_W-1:0] rf_addr,
    output logic                 rf_we,
    output logic [XLEN-1:0]      rf_wdata,
    input  logic [XLEN-1:0]      rf_rdata
);
    import rf_seq_pkg::*;

    state_t          state_q, state_d;
    logic [AW-1:0]   rs1_q, rs2_q;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [AW-1:0]   addr_sel;
    logic            gnt_rd, gnt_wr, arb_en, wr_fire, same_reg;

    assign arb_en = rst && (state_q == IDLE);

    rf_seq_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .rd_req (rd_req_valid),
        .wr_req (wb_valid),
        .gnt_rd (gnt_rd),
        .gnt_wr (gnt_wr)
    );

`ifdef RF_SEQ_SAME_REG_SKIP_EN
    assign same_reg = (rs1_q == rs2_q);
`else
    assign same_reg = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_rd) state_d = RD1;
            RD1:     state_d = same_reg ? HOLD : RD2;
            RD2:     state_d = HOLD;
            HOLD:    if (op_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The port is free for writeback in IDLE (when granted) and in HOLD.
    always_comb begin
        rd_req_ready = 1'b0;
        wb_ready     = 1'b0;
        wr_fire      = 1'b0;
        op_valid     = 1'b0;
        addr_sel     = '0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    rd_req_ready = gnt_rd;
                    wb_ready     = gnt_wr;
                    wr_fire      = gnt_wr;
                end
                RD1: addr_sel = rs1_q;
                RD2: addr_sel = rs2_q;
                HOLD: begin
                    op_valid = 1'b1;
                    wb_ready = wb_valid;
                    wr_fire  = wb_valid;
                end
                default: ;
            endcase
            if (wr_fire) addr_sel = wb_addr;
        end
    end

    assign rf_we       = wr_fire && (wb_addr != REG_ZERO);
    assign rf_wdata    = wr_fire ? wb_data : '0;
    assign rf_addr     = {{(RF_ADDR_W-AW){1'b0}}, addr_sel};
    assign op_rs1_data = op1_q;
    assign op_rs2_data = op2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rs1_q <= '0;
            rs2_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt_rd) begin
                    rs1_q <= rs1_addr;
                    rs2_q <= rs2_addr;
                end
                RD1: begin
                    op1_q <= (rs1_q == REG_ZERO) ? '0 : rf_rdata;
                    if (same_reg) op2_q <= (rs1_q == REG_ZERO) ? '0 : rf_rdata;
                end
                RD2: op2_q <= (rs2_q == REG_ZERO) ? '0 : rf_rdata;
                HOLD: if (rf_we) begin
                    // late writeback to a held source overrides the stale value
                    if (wb_addr == rs1_q) op1_q <= wb_data;
                    if (wb_addr == rs2_q) op2_q <= wb_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench for regfile_port_sequencer with a behavioural 32x32 register file.
module tb_regfile_port_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req_valid, rd_req_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        op_valid, op_ready;
    logic [31:0] op_rs1_data, op_rs2_data;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rf_addr;
    logic        rf_we;
    logic [31:0] rf_wdata, rf_rdata;

    logic [31:0] mem [32];
    logic        rdata_force;
    int          n_cmp, n_bad;

`ifdef RF_SEQ_SAME_REG_SKIP_EN
    localparam int SAME_LAT = 2;
`else
    localparam int SAME_LAT = 3;
`endif

    always #5 clk = ~clk;

    regfile_port_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_rs1_data  (op_rs1_data),
        .op_rs2_data  (op_rs2_data),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .rf_addr      (rf_addr),
        .rf_we        (rf_we),
        .rf_wdata     (rf_wdata),
        .rf_rdata     (rf_rdata)
    );

    assign rf_rdata = rdata_force ? 32'hFFFF_FFFF : mem[rf_addr[4:0]];

    always @(posedge clk) if (rf_we) mem[rf_addr[4:0]] <= rf_wdata;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_op(output int lat);
        lat = 1;
        while (op_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op;
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h5555_5555;
        rd_req_valid = 1'b1; rs1_addr = 5'd1; rs2_addr = 5'd2;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
            n_cmp++; if (rf_addr !== 32'd0) begin n_bad++; $display("FAIL reset_rf_addr got=%h exp=0", rf_addr); end
            n_cmp++; if (wb_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wb_ready got=%b exp=0", wb_ready); end
            n_cmp++; if (rd_req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rd_ready got=%b exp=0", rd_req_ready); end
            tick();
        end
        n_cmp++; if (op_valid !== 1'b0) begin n_bad++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
        n_cmp++; if (op_rs1_data !== 32'd0) begin n_bad++; $display("FAIL reset_op1 got=%h exp=0", op_rs1_data); end
        n_cmp++; if (op_rs2_data !== 32'd0) begin n_bad++; $display("FAIL reset_op2 got=%h exp=0", op_rs2_data); end
        n_cmp++; if (mem[5] !== 32'h1000_0005) begin n_bad++; $display("FAIL reset_no_write got=%h exp=10000005", mem[5]); end
        rst = 1'b1; wb_valid = 1'b0; rd_req_valid = 1'b0;
        #1;
    endtask

    task automatic test_contention;
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hA0A0_0010;
        rd_req_valid = 1'b1; rs1_addr = 5'd10; rs2_addr = 5'd11;
        #1;
        n_cmp++; if (wb_ready !== 1'b1 || rd_req_ready !== 1'b0) begin n_bad++; $display("FAIL arb_first got wb=%b rd=%b exp wb=1 rd=0", wb_ready, rd_req_ready); end
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 32'd10) begin n_bad++; $display("FAIL arb_first_write got we=%b addr=%h exp we=1 addr=a", rf_we, rf_addr); end
        tick();
        n_cmp++; if (rd_req_ready !== 1'b1 || wb_ready !== 1'b0) begin n_bad++; $display("FAIL arb_second got wb=%b rd=%b exp wb=0 rd=1", wb_ready, rd_req_ready); end
        tick();
        wb_valid = 1'b0; rd_req_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (op_valid !== 1'b1) begin n_bad++; $display("FAIL arb_op_valid got=%b exp=1", op_valid); end
        n_cmp++; if (op_rs1_data !== 32'hA0A0_0010) begin n_bad++; $display("FAIL arb_op1 got=%h exp=a0a00010", op_rs1_data); end
        n_cmp++; if (op_rs2_data !== 32'h1000_000B) begin n_bad++; $display("FAIL arb_op2 got=%h exp=1000000b", op_rs2_data); end
        finish_op();
        wb_valid = 1'b1; wb_addr = 5'd13; wb_data = 32'h0000_0013; rd_req_valid = 1'b1;
        #1;
        n_cmp++; if (wb_ready !== 1'b1 || rd_req_ready !== 1'b0) begin n_bad++; $display("FAIL arb_third got wb=%b rd=%b exp wb=1 rd=0", wb_ready, rd_req_ready); end
        tick();
        wb_valid = 1'b0; rd_req_valid = 1'b0;
        #1;
    endtask

    task automatic test_read_path;
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (wb_ready !== 1'b1 || rf_we !== 1'b1) begin n_bad++; $display("FAIL rp_write3 got rdy=%b we=%b exp 1 1", wb_ready, rf_we); end
        tick();
        wb_addr = 5'd7; wb_data = 32'h1234_5678;
        tick();
        wb_valid = 1'b0;
        rd_req_valid = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd7;
        #1;
        n_cmp++; if (rd_req_ready !== 1'b1) begin n_bad++; $display("FAIL rp_accept got=%b exp=1", rd_req_ready); end
        tick();
        rd_req_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'hBAD0_BAD0;
        #1;
        n_cmp++; if (op_valid !== 1'b0 || rf_addr !== 32'd3) begin n_bad++; $display("FAIL rp_rd1 got v=%b addr=%h exp v=0 addr=3", op_valid, rf_addr); end
        n_cmp++; if (wb_ready !== 1'b0 || rf_we !== 1'b0) begin n_bad++; $display("FAIL rp_rd1_nowb got rdy=%b we=%b exp 0 0", wb_ready, rf_we); end
        tick();
        n_cmp++; if (op_valid !== 1'b0 || rf_addr !== 32'd7 || wb_ready !== 1'b0) begin n_bad++; $display("FAIL rp_rd2 got v=%b addr=%h rdy=%b exp v=0 addr=7 rdy=0", op_valid, rf_addr, wb_ready); end
        wb_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (op_valid !== 1'b1 || op_rs1_data !== 32'hDEAD_BEEF || op_rs2_data !== 32'h1234_5678) begin
                n_bad++; $display("FAIL rp_hold%0d got v=%b op1=%h op2=%h exp v=1 op1=deadbeef op2=12345678", c, op_valid, op_rs1_data, op_rs2_data);
            end
            if (c < 4) tick();
        end
        finish_op();
        n_cmp++; if (op_valid !== 1'b0) begin n_bad++; $display("FAIL rp_release got=%b exp=0", op_valid); end
        n_cmp++; if (mem[20] !== 32'h1000_0014) begin n_bad++; $display("FAIL rp_no_rd_write got=%h exp=10000014", mem[20]); end
    endtask

    task automatic test_hold_forward;
        int lat;
        rd_req_valid = 1'b1; rs1_addr = 5'd9; rs2_addr = 5'd12;
        tick();
        rd_req_valid = 1'b0;
        wait_op(lat);
        n_cmp++; if (op_valid !== 1'b1 || lat !== 3) begin n_bad++; $display("FAIL fw_latency got v=%b lat=%0d exp v=1 lat=3", op_valid, lat); end
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hAAAA_0001;
        #1;
        n_cmp++; if (wb_ready !== 1'b1 || rf_we !== 1'b1 || rf_addr !== 32'd9) begin n_bad++; $display("FAIL fw_write got rdy=%b we=%b addr=%h exp 1 1 9", wb_ready, rf_we, rf_addr); end
        tick();
        wb_valid = 1'b0;
        #1;
        n_cmp++; if (op_rs1_data !== 32'hAAAA_0001) begin n_bad++; $display("FAIL fw_op1 got=%h exp=aaaa0001", op_rs1_data); end
        n_cmp++; if (op_rs2_data !== 32'h1000_000C || op_valid !== 1'b1) begin n_bad++; $display("FAIL fw_op2 got=%h v=%b exp=1000000c v=1", op_rs2_data, op_valid); end
        finish_op();
    endtask

    task automatic test_x0;
        int lat;
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (wb_ready !== 1'b1 || rf_we !== 1'b0) begin n_bad++; $display("FAIL x0_write got rdy=%b we=%b exp rdy=1 we=0", wb_ready, rf_we); end
        tick();
        wb_valid = 1'b0; rdata_force = 1'b1;
        rd_req_valid = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        rd_req_valid = 1'b0;
        wait_op(lat);
        n_cmp++; if (op_valid !== 1'b1 || op_rs1_data !== 32'd0 || op_rs2_data !== 32'd0) begin
            n_bad++; $display("FAIL x0_read got v=%b op1=%h op2=%h exp v=1 0 0", op_valid, op_rs1_data, op_rs2_data);
        end
        finish_op();
        rdata_force = 1'b0;
    endtask

    task automatic test_same_reg;
        int lat;
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444_CAFE;
        tick();
        wb_valid = 1'b0;
        rd_req_valid = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd4;
        #1;
        n_cmp++; if (rd_req_ready !== 1'b1) begin n_bad++; $display("FAIL same_accept got=%b exp=1", rd_req_ready); end
        tick();
        rd_req_valid = 1'b0;
        wait_op(lat);
        n_cmp++; if (lat !== SAME_LAT) begin n_bad++; $display("FAIL same_latency got=%0d exp=%0d", lat, SAME_LAT); end
        n_cmp++; if (op_rs1_data !== 32'h4444_CAFE || op_rs2_data !== 32'h4444_CAFE) begin
            n_bad++; $display("FAIL same_data got op1=%h op2=%h exp 4444cafe", op_rs1_data, op_rs2_data);
        end
        finish_op();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rdata_force = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + i;
        rst = 1'b0; op_ready = 1'b0; rd_req_valid = 1'b0; wb_valid = 1'b0;
        rs1_addr = '0; rs2_addr = '0; wb_addr = '0; wb_data = '0;
        test_reset();
        test_contention();
        test_read_path();
        test_hold_forward();
        test_x0();
        test_same_reg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
